delay_line_sched: RTL and testbench

- Round-robin issue scheduler that shares one fixed-latency, stall-free datapath (a LATENCY-deep register delay line or pipelined residue lane) among NUM_REQ requesters.
- Tags each issued operand with its requester ID and tracks the token alongside the pipeline, then returns results with that ID.
- Uses credit-based flow control against a downstream result buffer, because the datapath has no enable or stall input.

---
 rtl/delay_sched_pkg.sv | 29 ++
 rtl/delay_line_sched_rr_arbiter.sv | 49 ++++
 rtl/delay_line_sched.sv | 192 +++++++++++++++++++
 tb/tb_delay_line_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
// -----------------------------------------------------------------------------
// delay_sched_pkg
// Shared definitions for the lane issue schedulers:
//   CRED_W    - width of the credit counter seen on the scheduler interface
//   TAG_ID_W  - id width carried in a tag (wide enough for 8 requesters)
//   tag_t     - one delay-line tag stage {valid, id}
//   id_w()    - encoded requester id width for a given requester count
// -----------------------------------------------------------------------------
package delay_sched_pkg;

    localparam int CRED_W   = 8;
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Width of an encoded requester id; never narrower than one bit.
    function automatic int id_w(input int n);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/delay_line_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at ptr+1 and wraps
// modulo N; the first asserted request wins.
// Ports:
//   req  in  N      request vector
//   ptr  in  IDX_W  index of the most recently served requester
//   en   in  1      global enable; when low no grant is produced
//   gnt  out N      one-hot grant (or zero)
//   idx  out IDX_W  encoded index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = id_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found_s;
    logic hit_s;

    // Two-pass priority search: first the requesters above the pointer, then
    // wrap around to those at or below it. This avoids a modulo on the index.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            hit_s   = en && !found_s && req[i] && (IDX_W'(i) > ptr);
            gnt[i]  = gnt[i] | hit_s;
            idx     = hit_s ? IDX_W'(i) : idx;
            found_s = found_s | hit_s;
        end
        for (int i = 0; i < N; i++) begin
            hit_s   = en && !found_s && req[i] && (IDX_W'(i) <= ptr);
            gnt[i]  = gnt[i] | hit_s;
            idx     = hit_s ? IDX_W'(i) : idx;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/delay_line_sched.sv
// -----------------------------------------------------------------------------
// delay_line_sched
// Round-robin issue scheduler sharing one fixed-latency, stall-free datapath
// among NUM_REQ requesters. Every issued operand carries a {valid, id} tag
// through a tag delay line aligned with the datapath, so the result leaving
// the datapath LATENCY clocks later is returned with its requester id.
// Because the datapath cannot stall, issue is gated by credits for the
// downstream result buffer.
// Ports:
//   clk        in   1                   rising-edge clock
//   reset      in   1                   synchronous active-high reset
//   req_valid  in   NUM_REQ             per-requester operand valid
//   req_ready  out  NUM_REQ             grant, combinational, one-hot or zero
//   req_data   in   NUM_REQ*DATA_WIDTH  operands, requester i at [i*DW +: DW]
//   dp_in      out  DATA_WIDTH          operand into the datapath (0 if idle)
//   dp_out     in   DATA_WIDTH          datapath output, LATENCY clocks later
//   res_valid  out  1                   registered result strobe
//   res_data   out  DATA_WIDTH          registered result
//   res_id     out  ID_W                registered originating requester
//   res_credit in   1                   downstream freed one buffer entry
//   credits    out  8                   current credit count
//   busy       out  1                   token in flight or result pending
//   err        out  1                   sticky credit-overflow flag
// -----------------------------------------------------------------------------
module delay_line_sched
    import delay_sched_pkg::*;
#(
    parameter  int DATA_WIDTH = 18,
    parameter  int LATENCY    = 7,
    parameter  int NUM_REQ    = 2,
    parameter  int CREDITS    = 8,
    localparam int ID_W       = id_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [DATA_WIDTH-1:0]         dp_in,
    input  logic [DATA_WIDTH-1:0]         dp_out,
    output logic                          res_valid,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]               res_id,
    input  logic                          res_credit,
    output logic [CRED_W-1:0]             credits,
    output logic                          busy,
    output logic                          err
);

    localparam logic [CRED_W-1:0]   CRED_MAX  = CRED_W'(CREDITS);
    localparam logic [ID_W-1:0]     PTR_RESET = ID_W'(NUM_REQ - 1);
    localparam logic [TAG_ID_W:0]   ID_LIMIT  = (TAG_ID_W + 1)'(NUM_REQ);

    logic [ID_W-1:0]       ptr_r;
    logic [CRED_W-1:0]     credits_r;
    logic                  err_r;
    tag_t                  tag_r [LATENCY];
    logic                  res_valid_r;
    logic [DATA_WIDTH-1:0] res_data_r;
    logic [ID_W-1:0]       res_id_r;

    logic                  arb_en_s;
    logic [NUM_REQ-1:0]    gnt_s;
    logic [ID_W-1:0]       idx_s;
    logic                  issue_s;
    logic                  out_ok_s;
    logic                  busy_s;
    tag_t                  out_tag_s;

    // No grant while out of credits or while reset is held.
    assign arb_en_s = (credits_r != {CRED_W{1'b0}}) && !reset;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_r),
        .en  (arb_en_s),
        .gnt (gnt_s),
        .idx (idx_s)
    );

    // The arbiter only grants asserted requests, so any grant is a transfer.
    assign issue_s   = |gnt_s;
    assign req_ready = gnt_s;

    // Operand mux into the datapath; zero when nothing transfers.
    always_comb begin
        dp_in = '0;
        if (issue_s) begin
            dp_in = req_data[idx_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            dp_in = '0;
        end
    end

    assign out_tag_s = tag_r[LATENCY-1];
    // A tag whose id is out of range can only come from corrupted state; such
    // a token is dropped instead of being routed to a nonexistent requester.
    assign out_ok_s  = out_tag_s.valid && ({1'b0, out_tag_s.id} < ID_LIMIT);

    // Round-robin pointer: follows the last served requester only on transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= PTR_RESET;
        end else if (issue_s) begin
            ptr_r <= idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag delay line, shifted every clock in lockstep with the datapath;
    // clearing the valids on reset discards whatever is still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= '{valid: issue_s, id: TAG_ID_W'(idx_s)};
            for (int i = 1; i < LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Result register: captures the datapath output when its tag arrives;
    // data and id hold their last value between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_id_r    <= '0;
        end else if (out_ok_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= dp_out;
            res_id_r    <= out_tag_s.id[ID_W-1:0];
        end else begin
            res_valid_r <= 1'b0;
            res_data_r  <= res_data_r;
            res_id_r    <= res_id_r;
        end
    end

    // Credit counter and sticky overflow flag. An issue and a returned credit
    // in the same cycle cancel. A credit returned while already full means the
    // downstream buffer lost track; saturate and flag it.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_r <= CRED_MAX;
            err_r     <= 1'b0;
        end else begin
            case ({issue_s, res_credit})
                2'b10: begin
                    credits_r <= credits_r - CRED_W'(1);
                    err_r     <= err_r;
                end
                2'b01: begin
                    if (credits_r >= CRED_MAX) begin
                        credits_r <= CRED_MAX;
                        err_r     <= 1'b1;
                    end else begin
                        credits_r <= credits_r + CRED_W'(1);
                        err_r     <= err_r;
                    end
                end
                default: begin
                    credits_r <= credits_r;
                    err_r     <= err_r;
                end
            endcase
        end
    end

    // Busy whenever any tag stage holds a token or a result is being presented.
    always_comb begin
        busy_s = res_valid_r;
        for (int i = 0; i < LATENCY; i++) begin
            busy_s = busy_s | tag_r[i].valid;
        end
    end

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;
    assign credits   = credits_r;
    assign err       = err_r;
    assign busy      = busy_s;

endmodule

// File: tb/tb_delay_line_sched.sv
// -----------------------------------------------------------------------------
// tb_delay_line_sched
// Drives delay_line_sched with directed scenarios followed by a randomized
// phase. The reference model works on whole transactions: a credit count, a
// last-served index and a queue of expected results stamped with the cycle in
// which each must appear. A register delay line stands in for the datapath.
// -----------------------------------------------------------------------------
module tb_delay_line_sched;

    localparam int DW  = 18;
    localparam int LAT = 7;
    localparam int NR  = 2;
    localparam int CR  = 8;
    localparam int IW  = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_data;
    logic [DW-1:0]      dp_in;
    logic [DW-1:0]      dp_out;
    logic               res_valid;
    logic [DW-1:0]      res_data;
    logic [IW-1:0]      res_id;
    logic               res_credit;
    logic [7:0]         credits;
    logic               busy;
    logic               err;

    always #5 clk = ~clk;

    delay_line_sched #(
        .DATA_WIDTH (DW),
        .LATENCY    (LAT),
        .NUM_REQ    (NR),
        .CREDITS    (CR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .dp_in      (dp_in),
        .dp_out     (dp_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_credit (res_credit),
        .credits    (credits),
        .busy       (busy),
        .err        (err)
    );

    // Stand-in datapath: plain LATENCY-deep register delay line.
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= dp_in;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_out = pipe[LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    int            m_cred;
    int            m_ptr;
    logic          m_err;
    logic [DW-1:0] m_data;
    int            m_id;
    bit            hold_data = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_cred = CR;
        m_ptr  = NR - 1;
        m_err  = 1'b0;
        m_data = '0;
        m_id   = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic tick(input logic [NR-1:0] rv, input logic rc, input logic rst);
        int            g;
        int            c;
        logic [NR-1:0] e_rdy;
        logic [DW-1:0] e_dp;
        logic          e_rv;
        ent_t          e;
        @(posedge clk);
        #1;
        if (!hold_data) begin
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
        end
        req_valid  = rv;
        res_credit = rc;
        reset      = rst;
        #1;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        g = -1;
        if (!rst && m_cred > 0) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_ptr + k) % NR;
                if (rv[c] && g < 0) g = c;
            end
        end
        e_rdy = '0;
        e_dp  = '0;
        if (g >= 0) begin
            e_rdy[g] = 1'b1;
            e_dp     = req_data[g*DW +: DW];
        end
        e_rv = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_rv   = 1'b1;
            m_data = q[0].data;
            m_id   = q[0].id;
        end
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("dp_in",     32'(dp_in),     32'(e_dp));
        chk("res_valid", 32'(res_valid), 32'(e_rv));
        chk("res_data",  32'(res_data),  32'(m_data));
        chk("res_id",    32'(res_id),    32'(m_id));
        chk("credits",   32'(credits),   32'(m_cred));
        chk("err",       32'(err),       32'(m_err));
        chk("busy",      32'(busy),      32'(q.size() > 0));
        if (rst) begin
            m_reset();
        end else begin
            if (g >= 0) begin
                e.due  = cyc + LAT + 1;
                e.id   = g;
                e.data = req_data[g*DW +: DW];
                q.push_back(e);
                m_ptr = g;
            end
            if (g >= 0 && !rc) m_cred--;
            else if (g < 0 && rc) begin
                if (m_cred == CR) m_err = 1'b1;
                else m_cred++;
            end
        end
        cyc++;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        res_credit = 1'b0;
        req_data   = '0;
        m_reset();
        repeat (2) @(posedge clk);

        // Reset state, then a single issue from requester 0.
        repeat (5) tick(2'b00, 1'b0, 1'b0);
        hold_data = 1'b1;
        req_data[0*DW +: DW] = 18'h00ABC;
        tick(2'b01, 1'b0, 1'b0);
        hold_data = 1'b0;
        tick(2'b00, 1'b0, 1'b0);
        chk("single_credit_7", 32'(credits), 32'd7);
        repeat (9) tick(2'b00, 1'b0, 1'b0);
        tick(2'b00, 1'b1, 1'b0);

        // Round-robin with both requesters active.
        repeat (6) tick(2'b11, 1'b0, 1'b0);
        repeat (10) tick(2'b00, 1'b0, 1'b0);
        repeat (6) tick(2'b00, 1'b1, 1'b0);

        // Credit exhaustion on requester 1, then a single returned credit.
        repeat (10) tick(2'b10, 1'b0, 1'b0);
        chk("exhaust_credits", 32'(credits), 32'd0);
        chk("exhaust_ready",   32'(req_ready), 32'd0);
        tick(2'b10, 1'b1, 1'b0);
        repeat (3) tick(2'b10, 1'b0, 1'b0);
        repeat (8) tick(2'b00, 1'b1, 1'b0);
        repeat (4) tick(2'b00, 1'b0, 1'b0);

        // Issue and credit return in the same cycle at credits == 3.
        repeat (5) tick(2'b01, 1'b0, 1'b0);
        tick(2'b01, 1'b1, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        chk("simul_credits_3", 32'(credits), 32'd3);
        chk("simul_no_err",    32'(err), 32'd0);
        repeat (10) tick(2'b00, 1'b0, 1'b0);
        repeat (5) tick(2'b00, 1'b1, 1'b0);

        // Overflow: credit return while full sets the sticky error.
        tick(2'b00, 1'b1, 1'b0);
        repeat (3) tick(2'b00, 1'b0, 1'b0);
        chk("overflow_err",     32'(err), 32'd1);
        chk("overflow_credits", 32'(credits), 32'd8);

        // Reset while tokens are in flight.
        repeat (2) tick(2'b11, 1'b0, 1'b0);
        tick(2'b11, 1'b0, 1'b1);
        repeat (12) tick(2'b00, 1'b0, 1'b0);
        chk("midreset_busy",    32'(busy), 32'd0);
        chk("midreset_credits", 32'(credits), 32'd8);
        chk("midreset_err",     32'(err), 32'd0);

        // Randomized traffic, credit returns and occasional resets.
        for (int n = 0; n < 400; n++) begin
            tick(NR'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 99) == 0));
        end
        repeat (LAT + 3) tick(2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
